prince_round_ctrl: RTL and testbench



---
 rtl/prince_round_ctrl.sv | 138 +++++++++++++
 tb/tb_prince_round_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_round_ctrl.sv
// Round scheduler for the round-based, first-order masked PRINCE core.
// Drives the shared state register, masked S-box pipeline and linear-layer mux.
module prince_round_ctrl #(
    parameter int SBOX_LAT    = 2,
    parameter int HALF_ROUNDS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnd_valid,
    output logic       busy,
    output logic       done,
    output logic       load_en,
    output logic       state_en,
    output logic [1:0] lin_sel,
    output logic       rc_en,
    output logic [3:0] rc_idx,
    output logic       sbox_start,
    output logic       sbox_inv,
    output logic       out_en
);

    typedef enum logic [2:0] {IDLE, LOAD, SB_WAIT, LIN, FINAL} state_e;
    typedef enum logic [1:0] {FWD, MID1, MID2, BWD} phase_e;

    localparam logic [3:0] LAT_LAST  = 4'(SBOX_LAT - 1);
    localparam logic [3:0] FWD_LAST  = 4'(HALF_ROUNDS);
    localparam logic [3:0] BWD_FIRST = 4'(HALF_ROUNDS + 1);
    localparam logic [3:0] BWD_LAST  = 4'(2 * HALF_ROUNDS);

    state_e     state_q, state_d;
    phase_e     phase_q, phase_d;
    logic [3:0] round_q, round_d;
    logic [3:0] lat_q, lat_d;

    logic sbActive;

    // The launch cycle only counts once randomness is present; later cycles always count.
    assign sbActive = (state_q == SB_WAIT) && ((lat_q != 4'd0) || rnd_valid);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        round_d = round_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = SB_WAIT;
                phase_d = FWD;
                round_d = 4'd1;
                lat_d   = 4'd0;
            end
            SB_WAIT: begin
                if (sbActive) begin
                    if (lat_q == LAT_LAST) begin
                        lat_d = 4'd0;
                        if (phase_q == BWD && round_q == BWD_LAST) begin
                            state_d = FINAL;
                        end else begin
                            state_d = LIN;
                            if (phase_q == MID2) begin
                                phase_d = BWD;
                                round_d = BWD_FIRST;
                            end else if (phase_q == BWD) begin
                                round_d = round_q + 4'd1;
                            end
                        end
                    end else begin
                        lat_d = lat_q + 4'd1;
                    end
                end
            end
            LIN: begin
                state_d = SB_WAIT;
                case (phase_q)
                    FWD: begin
                        if (round_q == FWD_LAST) phase_d = MID1;
                        else                     round_d = round_q + 4'd1;
                    end
                    MID1:    phase_d = MID2;
                    default: phase_d = phase_q;
                endcase
            end
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= FWD;
            round_q <= 4'd0;
            lat_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            round_q <= round_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == FINAL);
        out_en     = (state_q == FINAL);
        load_en    = (state_q == LOAD);
        state_en   = (state_q == LIN);
        sbox_start = (state_q == SB_WAIT) && (lat_q == 4'd0) && rnd_valid;
        sbox_inv   = sbActive && (phase_q == MID2 || phase_q == BWD);
        lin_sel    = 2'b00;
        rc_en      = 1'b0;
        rc_idx     = 4'd0;
        if (state_q == LOAD) begin
            rc_en = 1'b1;
        end else if (state_q == LIN) begin
            case (phase_q)
                FWD: begin
                    lin_sel = 2'b00;
                    rc_en   = 1'b1;
                    rc_idx  = round_q;
                end
                MID1: lin_sel = 2'b01;
                default: begin
                    lin_sel = 2'b10;
                    rc_en   = 1'b1;
                    rc_idx  = round_q;
                end
            endcase
        end else if (state_q == FINAL) begin
            rc_idx = 4'd11;
        end
    end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Bench for prince_round_ctrl: three instances (SBOX_LAT 2, 1, 3) compared cycle by cycle
// against a step-list reference model, plus directed checks on counts and latencies.
module tb_prince_round_ctrl;

    localparam int NCYC = 420;

    typedef struct {
        int         kind;   // 0 load, 1 sbox, 2 linear, 3 final
        logic       inv;
        logic [1:0] sel;
        logic       rcEn;
        logic [3:0] rc;
    } step_t;

    logic clk = 1'b0;
    logic rst, start, rnd_valid;
    wire [13:0] obs [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        wire       busy, done, load_en, state_en, rc_en, sbox_start, sbox_inv, out_en;
        wire [1:0] lin_sel;
        wire [3:0] rc_idx;
        prince_round_ctrl #(.SBOX_LAT(LAT), .HALF_ROUNDS(5)) u_dut (
            .clk(clk), .rst(rst), .start(start), .rnd_valid(rnd_valid),
            .busy(busy), .done(done), .load_en(load_en), .state_en(state_en),
            .lin_sel(lin_sel), .rc_en(rc_en), .rc_idx(rc_idx),
            .sbox_start(sbox_start), .sbox_inv(sbox_inv), .out_en(out_en)
        );
        assign obs[g] = {busy, done, load_en, state_en, lin_sel, rc_en, rc_idx,
                         sbox_start, sbox_inv, out_en};
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    step_t      encSteps[$];
    logic       startV [NCYC];
    logic       rvV    [NCYC];
    logic       rstV   [NCYC];
    logic [13:0] expV  [3][NCYC];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int t);
        rst       = rstV[t];
        start     = startV[t];
        rnd_valid = rvV[t];
    endtask

    function automatic step_t mkStep(input int kind, input logic inv, input logic [1:0] sel,
                                     input logic rcEn, input logic [3:0] rc);
        step_t s;
        s.kind = kind; s.inv = inv; s.sel = sel; s.rcEn = rcEn; s.rc = rc;
        return s;
    endfunction

    function automatic logic [13:0] pack(input logic busy, input logic done, input logic ld,
                                         input logic st, input logic [1:0] sel, input logic rcEn,
                                         input logic [3:0] rc, input logic sbs, input logic inv,
                                         input logic oe);
        return {busy, done, ld, st, sel, rcEn, rc, sbs, inv, oe};
    endfunction

    // One encryption as an ordered list of datapath steps.
    function automatic void buildSteps();
        encSteps.delete();
        encSteps.push_back(mkStep(0, 1'b0, 2'b00, 1'b1, 4'd0));
        for (int r = 1; r <= 5; r++) begin
            encSteps.push_back(mkStep(1, 1'b0, 2'b00, 1'b0, 4'd0));
            encSteps.push_back(mkStep(2, 1'b0, 2'b00, 1'b1, 4'(r)));
        end
        encSteps.push_back(mkStep(1, 1'b0, 2'b00, 1'b0, 4'd0));
        encSteps.push_back(mkStep(2, 1'b0, 2'b01, 1'b0, 4'd0));
        encSteps.push_back(mkStep(1, 1'b1, 2'b00, 1'b0, 4'd0));
        for (int r = 6; r <= 10; r++) begin
            encSteps.push_back(mkStep(2, 1'b0, 2'b10, 1'b1, 4'(r)));
            encSteps.push_back(mkStep(1, 1'b1, 2'b00, 1'b0, 4'd0));
        end
        encSteps.push_back(mkStep(3, 1'b0, 2'b00, 1'b0, 4'd11));
    endfunction

    task automatic runModel(input int inst, input int lat);
        step_t       pend[$];
        step_t       s;
        int          prog;
        logic [13:0] v;
        prog = 0;
        for (int t = 0; t < NCYC; t++) begin
            v = '0;
            if (pend.size() == 0) begin
                if (!rstV[t] && startV[t]) pend = encSteps;
            end else begin
                s = pend[0];
                case (s.kind)
                    0: begin
                        v = pack(1, 0, 1, 0, 2'b00, 1, 4'd0, 0, 0, 0);
                        void'(pend.pop_front());
                    end
                    1: begin
                        if (prog == 0 && !rvV[t]) begin
                            v = pack(1, 0, 0, 0, 2'b00, 0, 4'd0, 0, 0, 0);
                        end else begin
                            v = pack(1, 0, 0, 0, 2'b00, 0, 4'd0, prog == 0, s.inv, 0);
                            prog++;
                            if (prog == lat) begin
                                void'(pend.pop_front());
                                prog = 0;
                            end
                        end
                    end
                    2: begin
                        v = pack(1, 0, 0, 1, s.sel, s.rcEn, s.rc, 0, 0, 0);
                        void'(pend.pop_front());
                    end
                    default: begin
                        v = pack(1, 1, 0, 0, 2'b00, 0, 4'd11, 0, 0, 1);
                        void'(pend.pop_front());
                    end
                endcase
            end
            if (rstV[t]) begin
                pend.delete();
                prog = 0;
            end
            expV[inst][t] = v;
        end
    endtask

    initial begin
        int          lats[3];
        int          firstDone[3];
        int          sbsCnt, invCnt, stCnt, ldCnt, oeCnt, doneCnt;
        logic [11:0] invSeq;
        int          rcQ[$];
        int          selQ[$];
        int          stallDone, gapSbs, loadQ[$], rstDone, idleAfterRst, freshDone;

        lats = '{2, 1, 3};
        firstDone = '{-1, -1, -1};
        sbsCnt = 0; invCnt = 0; stCnt = 0; ldCnt = 0; oeCnt = 0; doneCnt = 0;
        invSeq = '0; stallDone = -1; gapSbs = 0; rstDone = 0; idleAfterRst = -1;
        freshDone = -1;

        for (int t = 0; t < NCYC; t++) begin
            startV[t] = 1'b0; rvV[t] = 1'b1; rstV[t] = 1'b0;
        end
        startV[1] = 1'b1;
        startV[70] = 1'b1;
        rvV[81] = 1'b0; rvV[82] = 1'b0; rvV[83] = 1'b0;
        for (int t = 130; t <= 200; t++) startV[t] = 1'b1;
        startV[230] = 1'b1;
        rstV[253]   = 1'b1;
        startV[260] = 1'b1;
        startV[320] = 1'b1;
        for (int t = 321; t < NCYC; t++) rvV[t] = ($urandom_range(0, 3) != 0);

        buildSteps();
        for (int i = 0; i < 3; i++) runModel(i, lats[i]);

        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("reset_dut%0d", i), int'(obs[i]), 0);

        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk);
            #1;
            applyStimulus(t);
            #1;
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("cyc%0d_dut%0d", t, i), int'(obs[i]), int'(expV[i][t]));
                if (t < 60 && obs[i][12] && firstDone[i] < 0) firstDone[i] = t;
            end
            if (t < 60) begin
                if (obs[0][2]) begin
                    sbsCnt++;
                    invSeq = {invSeq[10:0], obs[0][1]};
                    if (obs[0][1]) invCnt++;
                end
                if (obs[0][10]) begin
                    stCnt++;
                    selQ.push_back(int'(obs[0][9:8]));
                end
                if (obs[0][7]) rcQ.push_back(int'(obs[0][6:3]));
                if (obs[0][11]) ldCnt++;
                if (obs[0][0]) oeCnt++;
                if (obs[0][12]) doneCnt++;
            end else if (t < 130) begin
                if (obs[0][12] && stallDone < 0) stallDone = t;
                if (t >= 81 && t <= 83 && obs[0][2]) gapSbs++;
            end else if (t < 230) begin
                if (obs[0][11]) loadQ.push_back(t);
            end else if (t < 260) begin
                if (obs[0][12]) rstDone++;
                if (t == 254) idleAfterRst = int'(obs[0]);
            end else if (t < 320) begin
                if (obs[0][12] && freshDone < 0) freshDone = t;
            end
        end

        checkOutput("done_lat2", firstDone[0], 38);
        checkOutput("done_lat1", firstDone[1], 26);
        checkOutput("done_lat3", firstDone[2], 50);
        checkOutput("sbox_start_count", sbsCnt, 12);
        checkOutput("sbox_inv_count", invCnt, 6);
        checkOutput("sbox_inv_order", int'(invSeq), 12'h03F);
        checkOutput("state_en_count", stCnt, 11);
        checkOutput("load_en_count", ldCnt, 1);
        checkOutput("out_en_count", oeCnt, 1);
        checkOutput("done_count", doneCnt, 1);
        checkOutput("rc_seq_len", rcQ.size(), 11);
        for (int k = 0; k < rcQ.size(); k++) checkOutput($sformatf("rc_seq%0d", k), rcQ[k], k);
        checkOutput("lin_seq_len", selQ.size(), 11);
        for (int k = 0; k < selQ.size(); k++)
            checkOutput($sformatf("lin_seq%0d", k), selQ[k], (k < 5) ? 0 : ((k == 5) ? 1 : 2));
        checkOutput("stall_done", stallDone, 110);
        checkOutput("stall_gap_launch", gapSbs, 0);
        checkOutput("held_load_count", loadQ.size(), 2);
        if (loadQ.size() == 2) begin
            checkOutput("held_load0", loadQ[0], 131);
            checkOutput("held_load1", loadQ[1], 169);
        end
        checkOutput("rst_no_done", rstDone, 0);
        checkOutput("rst_idle", idleAfterRst, 0);
        checkOutput("fresh_done", freshDone, 297);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
